// File: rtl/mkio_pkg.sv
// Shared types and field positions for the MKIO remote-terminal engine.
// Command word layout, FSM state encoding and status-word assembly.
package mkio_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DECODE,
        S_RX_WAIT,
        S_RX_STORE,
        S_GAP,
        S_STAT_SEND,
        S_TX_FETCH,
        S_TX_SEND,
        S_TX_WAIT,
        S_DONE
    } state_t;

    localparam int CMD_ADDR_HI = 15;
    localparam int CMD_ADDR_LO = 11;
    localparam int CMD_TR      = 10;
    localparam int CMD_SA_HI   = 9;
    localparam int CMD_SA_LO   = 5;
    localparam int CMD_WC_HI   = 4;
    localparam int CMD_WC_LO   = 0;

    localparam logic [4:0] BCAST_ADDR = 5'd31;

    localparam int STAT_ME  = 10;
    localparam int STAT_BCR = 4;

    function automatic logic [15:0] status_word(input logic [4:0] addr,
                                                input logic       me,
                                                input logic       bcr);
        logic [15:0] w;
        w           = '0;
        w[15:11]    = addr;
        w[STAT_ME]  = me;
        w[STAT_BCR] = bcr;
        return w;
    endfunction

endpackage

// File: rtl/mkio_rt_mem.sv
// Subaddress buffer: true dual-port RAM, one clock, registered read on both ports.
// Port A belongs to the message engine and wins a same-address write collision.
module mkio_rt_mem #(
    parameter int AW    = 7,
    parameter int DEPTH = 128
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_a_addr,
    input  logic          i_a_we,
    input  logic [15:0]   i_a_wdata,
    output logic [15:0]   o_a_rdata,
    input  logic [AW-1:0] i_b_addr,
    input  logic          i_b_we,
    input  logic [15:0]   i_b_wdata,
    output logic [15:0]   o_b_rdata
);

    logic [15:0] r_mem [0:DEPTH-1];

    // Port A is written last so its value survives an address collision.
    always_ff @(posedge i_clk) begin
        if (i_b_we) r_mem[i_b_addr] <= i_b_wdata;
        if (i_a_we) r_mem[i_a_addr] <= i_a_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_a_rdata <= '0;
            o_b_rdata <= '0;
        end else begin
            o_a_rdata <= r_mem[i_a_addr];
            o_b_rdata <= r_mem[i_b_addr];
        end
    end

endmodule

// File: rtl/mkio_rt_core.sv
// MIL-STD-1553 remote-terminal message engine: decodes commands, buffers BC->RT data, answers RT->BC.
// Status rises RESP_GAP clocks after the last word; tx words wait on the encoder's tx_busy handshake.
module mkio_rt_core
    import mkio_pkg::*;
#(
    parameter logic [4:0]  ADDRESS      = 5'd1,
    parameter int          NUM_SA       = 4,
    parameter logic [7:0]  RESP_GAP     = 8'd2,
    parameter logic [15:0] WORD_TIMEOUT = 16'd2000,
    localparam int         AW           = $clog2(NUM_SA) + 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_rx_done,
    input  logic [15:0]   i_rx_data,
    input  logic          i_rx_cd,
    input  logic          i_p_error,
    output logic [15:0]   o_tx_data,
    output logic          o_tx_cd,
    output logic          o_tx_ready,
    input  logic          i_tx_busy,
    input  logic [AW-1:0] i_host_addr,
    input  logic          i_host_we,
    input  logic [15:0]   i_host_wdata,
    output logic [15:0]   o_host_rdata,
    output logic          o_msg_done,
    output logic          o_msg_tr,
    output logic [4:0]    o_msg_sa,
    output logic          o_msg_err,
    output logic          o_busy
);

    localparam logic [4:0] LAST_SA = 5'(NUM_SA);

    state_t      r_state;
    logic        r_tr, r_bcast, r_me, r_bcr;
    logic [4:0]  r_sa;
    logic [5:0]  r_wc, r_cnt;
    logic [15:0] r_tmo, r_rx_dat, r_tx_data;
    logic [7:0]  r_gap;
    logic        r_tx_cd, r_tx_ready, r_msg_done, r_msg_tr, r_msg_err;
    logic [4:0]  r_msg_sa;

    logic          w_cmd, w_accept, w_c_tr, w_mode, w_legal, w_tmo_hit, w_gap_end, w_a_we;
    logic [4:0]    w_c_addr, w_c_sa, w_c_wc;
    logic [5:0]    w_c_wc32;
    logic [15:0]   w_tmo_nxt, w_a_rdata;
    logic [AW-1:0] w_a_addr;

    assign w_cmd    = i_rx_done & i_rx_cd;
    assign w_c_addr = i_rx_data[CMD_ADDR_HI:CMD_ADDR_LO];
    assign w_c_tr   = i_rx_data[CMD_TR];
    assign w_c_sa   = i_rx_data[CMD_SA_HI:CMD_SA_LO];
    assign w_c_wc   = i_rx_data[CMD_WC_HI:CMD_WC_LO];
    assign w_c_wc32 = (w_c_wc == 5'd0) ? 6'd32 : {1'b0, w_c_wc};
    assign w_accept = w_cmd && ((w_c_addr == ADDRESS) || (w_c_addr == BCAST_ADDR && !w_c_tr));

    assign w_mode    = (r_sa == 5'd0) || (r_sa == 5'd31);
    assign w_legal   = !w_mode && (r_sa <= LAST_SA);
    assign w_tmo_nxt = (r_tmo == 16'hFFFF) ? r_tmo : r_tmo + 16'd1;
    assign w_tmo_hit = (r_tmo == WORD_TIMEOUT - 16'd1);
    // GAP is entered one clock after the last word, hence the offset of 2.
    assign w_gap_end = ({1'b0, r_gap} + 9'd2) >= {1'b0, RESP_GAP};

    assign w_a_addr = AW'({r_sa - 5'd1, r_cnt[4:0]});
    assign w_a_we   = (r_state == S_RX_STORE) && w_legal;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_tr       <= 1'b0;
            r_bcast    <= 1'b0;
            r_me       <= 1'b0;
            r_bcr      <= 1'b0;
            r_sa       <= '0;
            r_wc       <= '0;
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_gap      <= '0;
            r_rx_dat   <= '0;
            r_tx_data  <= '0;
            r_tx_cd    <= 1'b0;
            r_tx_ready <= 1'b0;
            r_msg_done <= 1'b0;
            r_msg_tr   <= 1'b0;
            r_msg_sa   <= '0;
            r_msg_err  <= 1'b0;
        end else begin
            r_msg_done <= 1'b0;
            r_tmo      <= '0;
            r_gap      <= '0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_tr    <= w_c_tr;
                    r_sa    <= w_c_sa;
                    r_wc    <= w_c_wc32;
                    r_bcast <= (w_c_addr == BCAST_ADDR);
                    r_me    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (!w_mode && !w_legal) r_me <= 1'b1;
                    if (w_mode)     r_state <= r_bcast ? S_DONE : S_GAP;
                    else if (!r_tr) r_state <= S_RX_WAIT;
                    else            r_state <= S_GAP;
                end
                S_RX_WAIT: begin
                    r_tmo <= w_tmo_nxt;
                    if (w_cmd) begin
                        // A command mid-receive kills this message; a new one for us restarts decode.
                        r_msg_done <= 1'b1;
                        r_msg_err  <= 1'b1;
                        r_msg_tr   <= r_tr;
                        r_msg_sa   <= r_sa;
                        r_state    <= S_IDLE;
                        if (w_accept) begin
                            r_tr    <= w_c_tr;
                            r_sa    <= w_c_sa;
                            r_wc    <= w_c_wc32;
                            r_bcast <= (w_c_addr == BCAST_ADDR);
                            r_me    <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= S_DECODE;
                        end
                    end else if (i_rx_done) begin
                        r_rx_dat <= i_rx_data;
                        if (i_p_error) r_me <= 1'b1;
                        r_state <= S_RX_STORE;
                    end else if (w_tmo_hit) begin
                        r_msg_done <= 1'b1;
                        r_msg_err  <= 1'b1;
                        r_msg_tr   <= r_tr;
                        r_msg_sa   <= r_sa;
                        r_state    <= S_IDLE;
                    end
                end
                S_RX_STORE: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt + 6'd1 == r_wc) r_state <= r_bcast ? S_DONE : S_GAP;
                    else                      r_state <= S_RX_WAIT;
                end
                S_GAP: begin
                    r_gap <= r_gap + 8'd1;
                    if (w_gap_end) begin
                        r_tx_data  <= status_word(ADDRESS, r_me, r_bcr);
                        r_tx_cd    <= 1'b1;
                        r_tx_ready <= !i_tx_busy;
                        r_state    <= S_STAT_SEND;
                    end
                end
                S_STAT_SEND, S_TX_SEND: begin
                    r_tmo <= w_tmo_nxt;
                    if (r_tx_ready && i_tx_busy) begin
                        r_tx_ready <= 1'b0;
                        r_tmo      <= '0;
                        if (r_state == S_TX_SEND) r_cnt <= r_cnt + 6'd1;
                        r_state <= S_TX_WAIT;
                    end else if (w_tmo_hit) begin
                        r_tx_ready <= 1'b0;
                        r_msg_done <= 1'b1;
                        r_msg_err  <= 1'b1;
                        r_msg_tr   <= r_tr;
                        r_msg_sa   <= r_sa;
                        r_state    <= S_IDLE;
                    end else if (!r_tx_ready && !i_tx_busy) begin
                        r_tx_ready <= 1'b1;
                        if (r_state == S_TX_SEND) begin
                            r_tx_data <= w_a_rdata;
                            r_tx_cd   <= 1'b0;
                        end
                    end
                end
                S_TX_WAIT: begin
                    r_tmo <= w_tmo_nxt;
                    if (!i_tx_busy) begin
                        r_state <= (r_tr && w_legal && r_cnt < r_wc) ? S_TX_FETCH : S_DONE;
                    end else if (w_tmo_hit) begin
                        r_msg_done <= 1'b1;
                        r_msg_err  <= 1'b1;
                        r_msg_tr   <= r_tr;
                        r_msg_sa   <= r_sa;
                        r_state    <= S_IDLE;
                    end
                end
                S_TX_FETCH: r_state <= S_TX_SEND;
                S_DONE: begin
                    r_msg_done <= 1'b1;
                    r_msg_err  <= r_me;
                    r_msg_tr   <= r_tr;
                    r_msg_sa   <= r_sa;
                    r_bcr      <= r_bcast;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    mkio_rt_mem #(.AW(AW), .DEPTH(NUM_SA * 32)) u_mem (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_a_addr  (w_a_addr),
        .i_a_we    (w_a_we),
        .i_a_wdata (r_rx_dat),
        .o_a_rdata (w_a_rdata),
        .i_b_addr  (i_host_addr),
        .i_b_we    (i_host_we),
        .i_b_wdata (i_host_wdata),
        .o_b_rdata (o_host_rdata)
    );

    assign o_tx_data  = r_tx_data;
    assign o_tx_cd    = r_tx_cd;
    assign o_tx_ready = r_tx_ready;
    assign o_msg_done = r_msg_done;
    assign o_msg_tr   = r_msg_tr;
    assign o_msg_sa   = r_msg_sa;
    assign o_msg_err  = r_msg_err;
    assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mkio_rt_core.sv
// Directed bench for mkio_rt_core: receive, broadcast, transmit, mode code, abort, timeout, reset.
module tb_mkio_rt_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_done, rx_cd, p_error, tx_busy, host_we;
    logic [15:0] rx_data, host_wdata;
    logic [6:0]  host_addr;
    logic [15:0] tx_data, host_rdata;
    logic        tx_cd, tx_ready, msg_done, msg_tr, msg_err, busy;
    logic [4:0]  msg_sa;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mkio_rt_core dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_done    (rx_done),
        .i_rx_data    (rx_data),
        .i_rx_cd      (rx_cd),
        .i_p_error    (p_error),
        .o_tx_data    (tx_data),
        .o_tx_cd      (tx_cd),
        .o_tx_ready   (tx_ready),
        .i_tx_busy    (tx_busy),
        .i_host_addr  (host_addr),
        .i_host_we    (host_we),
        .i_host_wdata (host_wdata),
        .o_host_rdata (host_rdata),
        .o_msg_done   (msg_done),
        .o_msg_tr     (msg_tr),
        .o_msg_sa     (msg_sa),
        .o_msg_err    (msg_err),
        .o_busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic cd, input logic pe);
        @(negedge clk);
        rx_data = d; rx_cd = cd; p_error = pe; rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; rx_cd = 1'b0; p_error = 1'b0;
    endtask

    task automatic wait_ready(input string tag, output int lat);
        lat = 0;
        while (!tx_ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!tx_ready) chk({tag, " ready"}, tx_ready, 1);
    endtask

    task automatic encode(input string tag);
        tx_busy = 1'b1;
        @(negedge clk);
        chk({tag, " ready drop"}, tx_ready, 0);
        repeat (2) @(negedge clk);
        tx_busy = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc, output int cyc);
        cyc = 0;
        while (!msg_done && cyc < maxc) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done"}, msg_done, 1);
    endtask

    task automatic host_wr(input logic [6:0] a, input logic [15:0] d);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic host_rd(input logic [6:0] a, output logic [15:0] d);
        host_addr = a;
        @(negedge clk);
        d = host_rdata;
    endtask

    initial begin
        int          lat, cyc;
        logic [15:0] d, exp_d;
        logic        seen;
        rst_n = 1'b1; rx_done = 1'b0; rx_cd = 1'b0; p_error = 1'b0; rx_data = '0;
        tx_busy = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst tx_ready", tx_ready, 0);
        chk("rst busy", busy, 0);
        chk("rst msg_done", msg_done, 0);
        chk("rst msg_err", msg_err, 0);
        chk("rst tx_data", tx_data, 0);
        chk("rst host_rdata", host_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain receive to SA2, 3 words
        send_word(16'h0843, 1'b1, 1'b0);
        chk("t1 busy", busy, 1);
        send_word(16'h00A1, 1'b0, 1'b0);
        send_word(16'h00A2, 1'b0, 1'b0);
        send_word(16'h00A3, 1'b0, 1'b0);
        wait_ready("t1 stat", lat);
        chk("t1 gap", lat, 2);
        chk("t1 status", tx_data, 16'h0800);
        chk("t1 cd", tx_cd, 1);
        encode("t1");
        wait_done("t1", 20, cyc);
        chk("t1 err", msg_err, 0);
        chk("t1 sa", msg_sa, 2);
        chk("t1 tr", msg_tr, 0);
        for (int i = 0; i < 3; i++) begin
            host_rd(7'(32 + i), d);
            chk("t1 ram", d, 16'h00A1 + 16'(i));
        end

        // Parity error on word 2
        send_word(16'h0843, 1'b1, 1'b0);
        send_word(16'h00B1, 1'b0, 1'b0);
        send_word(16'h00B2, 1'b0, 1'b1);
        send_word(16'h00B3, 1'b0, 1'b0);
        wait_ready("t2 stat", lat);
        chk("t2 status", tx_data, 16'h0C00);
        encode("t2");
        wait_done("t2", 20, cyc);
        chk("t2 err", msg_err, 1);
        for (int i = 0; i < 3; i++) begin
            host_rd(7'(32 + i), d);
            chk("t2 ram", d, 16'h00B1 + 16'(i));
        end

        // Broadcast receive to SA1, then transmit all 32 words of SA1
        for (int i = 0; i < 32; i++) host_wr(7'(i), 16'h1000 + 16'(i));
        send_word(16'hF822, 1'b1, 1'b0);
        send_word(16'h00C1, 1'b0, 1'b0);
        send_word(16'h00C2, 1'b0, 1'b0);
        seen = 1'b0;
        cyc  = 0;
        while (!msg_done && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (tx_ready) seen = 1'b1;
        end
        chk("t3 bc done", msg_done, 1);
        chk("t3 bc no status", seen, 0);
        chk("t3 bc sa", msg_sa, 1);
        chk("t3 bc err", msg_err, 0);
        send_word(16'h0C20, 1'b1, 1'b0);
        wait_ready("t3 stat", lat);
        chk("t3 gap", lat, 2);
        chk("t3 status bcr", tx_data, 16'h0810);
        encode("t3 stat");
        for (int i = 0; i < 32; i++) begin
            exp_d = (i == 0) ? 16'h00C1 : (i == 1) ? 16'h00C2 : 16'h1000 + 16'(i);
            wait_ready("t3 word", lat);
            chk($sformatf("t3 word%0d", i), tx_data, exp_d);
            chk("t3 word cd", tx_cd, 0);
            encode("t3 word");
        end
        wait_done("t3 tx", 40, cyc);
        chk("t3 tx tr", msg_tr, 1);
        chk("t3 tx err", msg_err, 0);

        // Host-preloaded transmit, 2 words
        host_wr(7'd0, 16'h1111);
        host_wr(7'd1, 16'h2222);
        send_word(16'h0C22, 1'b1, 1'b0);
        wait_ready("t4 stat", lat);
        chk("t4 status", tx_data, 16'h0800);
        chk("t4 stat cd", tx_cd, 1);
        encode("t4 stat");
        wait_ready("t4 w0", lat);
        chk("t4 w0", tx_data, 16'h1111);
        chk("t4 w0 cd", tx_cd, 0);
        encode("t4 w0");
        wait_ready("t4 w1", lat);
        chk("t4 w1", tx_data, 16'h2222);
        chk("t4 w1 cd", tx_cd, 0);
        encode("t4 w1");
        wait_done("t4", 20, cyc);
        chk("t4 err", msg_err, 0);

        // Mode code: status only
        send_word(16'h0C02, 1'b1, 1'b0);
        wait_ready("t5 stat", lat);
        chk("t5 gap", lat, 2);
        chk("t5 status", tx_data, 16'h0800);
        encode("t5");
        wait_done("t5", 20, cyc);
        chk("t5 sa", msg_sa, 0);
        chk("t5 err", msg_err, 0);

        // Receive to SA5 (beyond NUM_SA)
        send_word(16'h08A2, 1'b1, 1'b0);
        send_word(16'h0055, 1'b0, 1'b0);
        send_word(16'h0066, 1'b0, 1'b0);
        wait_ready("t6 stat", lat);
        chk("t6 status", tx_data, 16'h0C00);
        encode("t6");
        wait_done("t6", 20, cyc);
        chk("t6 err", msg_err, 1);

        // New command mid-receive aborts, second completes
        send_word(16'h0843, 1'b1, 1'b0);
        send_word(16'h00D1, 1'b0, 1'b0);
        send_word(16'h0841, 1'b1, 1'b0);
        chk("t7 abort done", msg_done, 1);
        chk("t7 abort err", msg_err, 1);
        chk("t7 busy", busy, 1);
        send_word(16'h00E1, 1'b0, 1'b0);
        wait_ready("t7 stat", lat);
        chk("t7 status", tx_data, 16'h0800);
        encode("t7");
        wait_done("t7", 20, cyc);
        chk("t7 err", msg_err, 0);
        host_rd(7'd32, d);
        chk("t7 ram", d, 16'h00E1);

        // Ignored commands
        send_word(16'h1043, 1'b1, 1'b0);
        chk("t8 other addr busy", busy, 0);
        send_word(16'hFC22, 1'b1, 1'b0);
        chk("t8 bcast tx busy", busy, 0);
        repeat (5) @(negedge clk);
        chk("t8 no ready", tx_ready, 0);

        // Stalled receive times out
        send_word(16'h0843, 1'b1, 1'b0);
        send_word(16'h5A5A, 1'b0, 1'b0);
        wait_done("t9", 2100, cyc);
        chk("t9 cycles", cyc, 2001);
        chk("t9 err", msg_err, 1);
        chk("t9 busy", busy, 0);

        // Reset pulse during transmit
        send_word(16'h0C22, 1'b1, 1'b0);
        wait_ready("t10 stat", lat);
        encode("t10 stat");
        wait_ready("t10 w0", lat);
        chk("t10 ready before rst", tx_ready, 1);
        rst_n = 1'b0;
        #1;
        chk("t10 rst ready", tx_ready, 0);
        chk("t10 rst busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        host_rd(7'd32, d);
        chk("t10 ram kept", d, 16'h5A5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
